button_conditioner: RTL and testbench



---
 rtl/button_pkg.sv | 33 +++
 rtl/button_channel.sv | 117 +++++++++++
 rtl/button_conditioner.sv | 42 ++++
 tb/tb_button_conditioner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and elaboration helpers for the panel button conditioner.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        REL_DB   = 3'd4
    } btn_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit params_ok(
        input int nbtn,
        input int sync,
        input int db,
        input int ren,
        input int dly,
        input int per
    );
        return (nbtn >= 1) && (sync >= 2) && (db >= 1) &&
               (ren == 0 || ren == 1) && (dly >= 2) && (per >= 2);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, press/release debounce and auto-repeat.
module button_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic bi,
    output logic bo,
    output logic rpt,
    output logic held
);

    localparam int DW   = clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = clog2(RMAX);

    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    btn_state_t             st;
    logic [DW-1:0]          dcnt;
    logic [RW-1:0]          rcnt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge Clk) begin
        if (Rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], bi};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st   <= IDLE;
            dcnt <= '0;
            rcnt <= '0;
            bo   <= 1'b0;
            rpt  <= 1'b0;
            held <= 1'b0;
        end else begin
            bo  <= 1'b0;
            rpt <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            st   <= HELD;
                            bo   <= 1'b1;
                            held <= 1'b1;
                            rcnt <= '0;
                        end else begin
                            st   <= PRESS_DB;
                            dcnt <= D_ONE;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!s) begin
                        st <= IDLE;
                    end else if (dcnt == D_LAST) begin
                        st   <= HELD;
                        bo   <= 1'b1;
                        held <= 1'b1;
                        rcnt <= '0;
                    end else begin
                        dcnt <= dcnt + D_ONE;
                    end
                end
                HELD, REPEAT: begin
                    if (!s) begin
                        // a single-sample debounce releases immediately
                        if (DEBOUNCE_CYCLES == 1) begin
                            st   <= IDLE;
                            held <= 1'b0;
                        end else begin
                            st   <= REL_DB;
                            dcnt <= D_ONE;
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (rcnt == ((st == HELD) ? R_DLY : R_PER)) begin
                            st   <= REPEAT;
                            bo   <= 1'b1;
                            rpt  <= 1'b1;
                            rcnt <= '0;
                        end else begin
                            rcnt <= rcnt + R_ONE;
                        end
                    end
                end
                REL_DB: begin
                    if (s) begin
                        st   <= HELD;
                        rcnt <= '0;
                    end else if (dcnt == D_LAST) begin
                        st   <= IDLE;
                        held <= 1'b0;
                    end else begin
                        dcnt <= dcnt + D_ONE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel pushbutton conditioner feeding the vending front-panel FSM.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_BTN-1:0] bi,
    output logic [NUM_BTN-1:0] bo,
    output logic [NUM_BTN-1:0] rpt,
    output logic [NUM_BTN-1:0] held
);

    if (!params_ok(NUM_BTN, SYNC_STAGES, DEBOUNCE_CYCLES,
                   REPEAT_EN, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_bad
        $error("button_conditioner: illegal parameter set");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .Clk (Clk),
            .Rst (Rst),
            .bi  (bi[i]),
            .bo  (bo[i]),
            .rpt (rpt[i]),
            .held(held[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: three builds share bi/Rst and are checked against a run-length model.
module tb_button_conditioner;

    logic            Clk;
    logic            Rst;
    logic [3:0]      bi;
    logic [2:0][3:0] bo_a, rpt_a, held_a;

    button_conditioner #(
        .NUM_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u0 (
        .Clk(Clk), .Rst(Rst), .bi(bi),
        .bo(bo_a[0]), .rpt(rpt_a[0]), .held(held_a[0])
    );

    button_conditioner #(
        .NUM_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u1 (
        .Clk(Clk), .Rst(Rst), .bi(bi),
        .bo(bo_a[1]), .rpt(rpt_a[1]), .held(held_a[1])
    );

    button_conditioner #(
        .NUM_BTN(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1),
        .REPEAT_EN(1), .REPEAT_DELAY(3), .REPEAT_PERIOD(2)
    ) u2 (
        .Clk(Clk), .Rst(Rst), .bi(bi),
        .bo(bo_a[2]), .rpt(rpt_a[2]), .held(held_a[2])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0][3:0] bo;
        logic [2:0][3:0] rpt;
        logic [2:0][3:0] held;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    int sy_p[3] = '{2, 2, 3};
    int db_p[3] = '{4, 4, 1};
    int re_p[3] = '{1, 0, 1};
    int dl_p[3] = '{10, 10, 3};
    int pr_p[3] = '{5, 5, 2};

    bit hist[3][4][4];
    bit pressed[3][4];
    int ones[3][4];
    int zeros[3][4];
    int anchor[3][4];

    logic [63:0] pm, rm, hm, pm1;
    int          idx;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Model: a press is DB consecutive high samples, a release DB lows;
    // repeats fall at anchor+DELAY+k*PERIOD while the sample stays high.
    task automatic step();
        exp_t e;
        bit   s;
        int   el;
        e = '0;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (Rst) begin
                    for (int k = 0; k < 4; k++) hist[d][c][k] = 1'b0;
                    pressed[d][c] = 1'b0;
                    ones[d][c]    = 0;
                    zeros[d][c]   = 0;
                end else begin
                    s = hist[d][c][sy_p[d]-1];
                    for (int k = 3; k > 0; k--) hist[d][c][k] = hist[d][c][k-1];
                    hist[d][c][0] = bi[c];
                    if (s) begin
                        ones[d][c]++;
                        zeros[d][c] = 0;
                    end else begin
                        zeros[d][c]++;
                        ones[d][c] = 0;
                    end
                    if (!pressed[d][c]) begin
                        if (s && ones[d][c] == db_p[d]) begin
                            pressed[d][c] = 1'b1;
                            e.bo[d][c]    = 1'b1;
                            anchor[d][c]  = cyc;
                        end
                    end else if (!s) begin
                        if (zeros[d][c] == db_p[d]) pressed[d][c] = 1'b0;
                    end else if (ones[d][c] == 1) begin
                        anchor[d][c] = cyc;
                    end else if (re_p[d] != 0) begin
                        el = cyc - anchor[d][c];
                        if (el >= dl_p[d] && (el - dl_p[d]) % pr_p[d] == 0) begin
                            e.bo[d][c]  = 1'b1;
                            e.rpt[d][c] = 1'b1;
                        end
                    end
                    e.held[d][c] = pressed[d][c];
                end
            end
        end
        expq.push_back(e);
        @(posedge Clk);
        cyc++;
        #1;
    endtask

    task automatic track(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            idx++;
            if (bo_a[0][ch])   pm[idx]  = 1'b1;
            if (rpt_a[0][ch])  rm[idx]  = 1'b1;
            if (held_a[0][ch]) hm[idx]  = 1'b1;
            if (bo_a[1][ch])   pm1[idx] = 1'b1;
        end
    endtask

    task automatic clr_track();
        idx = 0;
        pm  = '0;
        rm  = '0;
        hm  = '0;
        pm1 = '0;
    endtask

    always @(negedge Clk) begin
        exp_t me;
        if (expq.size() != 0) begin
            me = expq.pop_front();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("u%0d_bo@%0d", d, cyc), 64'(bo_a[d]), 64'(me.bo[d]));
                chk($sformatf("u%0d_rpt@%0d", d, cyc), 64'(rpt_a[d]), 64'(me.rpt[d]));
                chk($sformatf("u%0d_held@%0d", d, cyc), 64'(held_a[d]), 64'(me.held[d]));
            end
        end
    end

    initial begin
        logic [63:0] ep, er, eh;
        int          pr;
        int          ar[7];
        int          bb[6];

        Rst = 1'b1;
        bi  = '0;
        step();
        step();
        chk("reset_held", 64'(held_a[0]), 64'h0);
        chk("reset_bo", 64'(bo_a[0]), 64'h0);
        Rst = 1'b0;

        bi = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 5) chk("clean_bo_early", 64'(bo_a[0]), 64'h0);
            if (k == 6) begin
                chk("clean_bo", 64'(bo_a[0]), 64'h1);
                chk("clean_held", 64'(held_a[0]), 64'h1);
                chk("clean_rpt", 64'(rpt_a[0]), 64'h0);
            end
        end
        bi = '0;
        repeat (12) step();

        clr_track();
        bb = '{1, 1, 0, 1, 1, 0};
        for (int k = 0; k < 6; k++) begin
            bi[1] = bb[k][0];
            track(1, 1);
        end
        bi = '0;
        track(1, 12);
        chk("bounce_bo", pm, 64'h0);
        chk("bounce_held", hm, 64'h0);

        clr_track();
        bi = 4'b0100;
        track(2, 40);
        bi = '0;
        track(2, 15);
        ar = '{6, 16, 21, 26, 31, 36, 41};
        ep = '0;
        er = '0;
        eh = '0;
        for (int k = 0; k < 7; k++) begin
            ep[ar[k]] = 1'b1;
            if (k != 0) er[ar[k]] = 1'b1;
        end
        for (int k = 6; k <= 45; k++) eh[k] = 1'b1;
        chk("repeat_bo", pm, ep);
        chk("repeat_rpt", rm, er);
        chk("repeat_held", hm, eh);
        ep = '0;
        ep[6] = 1'b1;
        chk("norepeat_bo", pm1, ep);

        clr_track();
        bi = 4'b1000;
        track(3, 10);
        bi = '0;
        track(3, 2);
        bi = 4'b1000;
        track(3, 20);
        bi = '0;
        track(3, 10);
        ep = '0;
        er = '0;
        eh = '0;
        ep[6]  = 1'b1;
        ep[25] = 1'b1;
        ep[30] = 1'b1;
        er[25] = 1'b1;
        er[30] = 1'b1;
        for (int k = 6; k <= 37; k++) eh[k] = 1'b1;
        chk("relbounce_bo", pm, ep);
        chk("relbounce_rpt", rm, er);
        chk("relbounce_held", hm, eh);

        bi = 4'b1111;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) chk("simul_bo_early", 64'(bo_a[0]), 64'h0);
            if (k == 6) chk("simul_bo", 64'(bo_a[0]), 64'hf);
        end
        Rst = 1'b1;
        step();
        chk("rst_bo", 64'(bo_a[0]), 64'h0);
        chk("rst_held", 64'(held_a[0]), 64'h0);
        chk("rst_rpt", 64'(rpt_a[0]), 64'h0);
        Rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 5) chk("rerun_bo_early", 64'(bo_a[0]), 64'h0);
            if (k == 6) chk("rerun_bo", 64'(bo_a[0]), 64'hf);
        end
        bi = '0;
        repeat (12) step();

        for (int seg = 0; seg < 12; seg++) begin
            pr = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 8 : 40);
            for (int k = 0; k < 60; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(pr - 1, 0) == 0) bi[c] = ~bi[c];
                end
                Rst = ($urandom_range(299, 0) == 0);
                step();
            end
        end
        Rst = 1'b0;
        bi  = '0;
        repeat (20) step();

        for (int k = 0; k < 5 && expq.size() != 0; k++) @(negedge Clk);
        #1;
        chk("drain", 64'(expq.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
